// File: rtl/reg_file_pkg.sv
// Shared register-file constants for the integer pipeline.
// Width defaults used by reg_file, its scoreboard and its bus interface.
package reg_file_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

endpackage

// File: rtl/reg_file_if.sv
// Writeback, read and issue signals of the register file.
// master drives requests; slave is the register file itself.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int DW = reg_file_pkg::DATA_W,
  parameter int AW = reg_file_pkg::ADDR_W
);

  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          re;
  logic [AW-1:0] raddr_a;
  logic [AW-1:0] raddr_b;
  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;
  logic          rvalid;
  logic          issue;
  logic [AW-1:0] issue_addr;
  logic          stall;

  modport master (
    output we, waddr, wdata,
    output re, raddr_a, raddr_b,
    output issue, issue_addr,
    input  rdata_a, rdata_b, rvalid, stall
  );

  modport slave (
    input  we, waddr, wdata,
    input  re, raddr_a, raddr_b,
    input  issue, issue_addr,
    output rdata_a, rdata_b, rvalid, stall
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for pending multi-cycle writers.
// Raises stall when a requested read names a register still in flight.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_issue,
  input  logic [ADDR_W-1:0] i_issue_addr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic              o_stall
);

  localparam int N = 2 ** ADDR_W;

  logic [N-1:0] r_busy;
  logic [N-1:0] w_busy_nxt;
  logic [N-1:0] w_busy_eff;

  // Issue is applied after the clear so a new writer wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_we)
      w_busy_nxt[i_waddr] = 1'b0;
    if (i_issue)
      w_busy_nxt[i_issue_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // A write landing this cycle is bypassed, so it no longer blocks.
  always_comb begin
    w_busy_eff = r_busy;
    if (i_we)
      w_busy_eff[i_waddr] = 1'b0;
  end

  assign o_stall = i_re &&
    (w_busy_eff[i_raddr_a] || w_busy_eff[i_raddr_b]);

  always_ff @(posedge clk) begin
    if (rst)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with write-first bypass,
// registered read data and a busy scoreboard for load hazards.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  localparam int N = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [N];
  logic [DATA_W-1:0] r_rdata_a;
  logic [DATA_W-1:0] r_rdata_b;
  logic              r_rvalid;

  logic              w_stall;
  logic              w_acc;
  logic              w_wr;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  reg_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .i_issue      (bus.issue),
    .i_issue_addr (bus.issue_addr),
    .i_we         (bus.we),
    .i_waddr      (bus.waddr),
    .i_re         (bus.re),
    .i_raddr_a    (bus.raddr_a),
    .i_raddr_b    (bus.raddr_b),
    .o_stall      (w_stall)
  );

  assign w_acc = bus.re && !w_stall;
  assign w_wr  = bus.we && (bus.waddr != '0);

  always_comb begin
    w_rd_a = r_regs[bus.raddr_a];
    if (bus.raddr_a == '0)
      w_rd_a = '0;
    else if (w_wr && bus.waddr == bus.raddr_a)
      w_rd_a = bus.wdata;
  end

  always_comb begin
    w_rd_b = r_regs[bus.raddr_b];
    if (bus.raddr_b == '0)
      w_rd_b = '0;
    else if (w_wr && bus.waddr == bus.raddr_b)
      w_rd_b = bus.wdata;
  end

  // Index 0 is never written, so it stays at its reset value of 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[bus.waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
      r_rvalid  <= 1'b0;
    end else begin
      r_rvalid <= w_acc;
      if (w_acc) begin
        r_rdata_a <= w_rd_a;
        r_rdata_b <= w_rd_b;
      end
    end
  end

  assign bus.rdata_a = r_rdata_a;
  assign bus.rdata_b = r_rdata_b;
  assign bus.rvalid  = r_rvalid;
  assign bus.stall   = w_stall;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: stimulus queues expected read data,
// a monitor compares whenever rvalid is presented.
module tb_reg_file;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_file_if bus ();

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [63:0] exp_q [$];
  logic [31:0] m [16];

  task automatic idle_in();
    bus.we = 0; bus.waddr = '0; bus.wdata = '0;
    bus.re = 0; bus.raddr_a = '0; bus.raddr_b = '0;
    bus.issue = 0; bus.issue_addr = '0;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(
    input logic        we,
    input logic [3:0]  wa,
    input logic [31:0] wd,
    input logic        re,
    input logic [3:0]  ra,
    input logic [3:0]  rb,
    input logic        is,
    input logic [3:0]  ia,
    input logic        exp_stall,
    input string       nm
  );
    logic [31:0] ea, eb;
    bus.we = we; bus.waddr = wa; bus.wdata = wd;
    bus.re = re; bus.raddr_a = ra; bus.raddr_b = rb;
    bus.issue = is; bus.issue_addr = ia;
    @(negedge clk);
    chk({nm, ".stall"}, 32'(bus.stall), 32'(exp_stall));
    if (re && !exp_stall) begin
      ea = (ra == 0) ? 32'h0 : (we && wa == ra) ? wd : m[ra];
      eb = (rb == 0) ? 32'h0 : (we && wa == rb) ? wd : m[rb];
      exp_q.push_back({ea, eb});
    end
    @(posedge clk);
    if (we && wa != 0) m[wa] = wd;
    #1;
    idle_in();
  endtask

  task automatic do_reset();
    rst = 1;
    bus.we = 1; bus.waddr = 4'd5; bus.wdata = 32'h5555;
    bus.re = 1; bus.raddr_a = 4'd5; bus.raddr_b = 4'd1;
    bus.issue = 1; bus.issue_addr = 4'd6;
    @(posedge clk); #1;
    idle_in();
    rst = 0;
    for (int i = 0; i < 16; i++) m[i] = 0;
    @(negedge clk);
    chk("rst.rdata_a", bus.rdata_a, 32'h0);
    chk("rst.rdata_b", bus.rdata_b, 32'h0);
    chk("rst.rvalid", 32'(bus.rvalid), 32'h0);
    chk("rst.stall", 32'(bus.stall), 32'h0);
    @(posedge clk); #1;
  endtask

  // Monitor: samples 2 units after each edge, away from stimulus.
  initial begin
    logic [63:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (rst === 1'b0 || rst === 1'b1) begin
        if (bus.rvalid) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL spurious_rvalid: got 1 expected 0");
          end else begin
            e = exp_q.pop_front();
            chk("rdata_a", bus.rdata_a, e[63:32]);
            chk("rdata_b", bus.rdata_b, e[31:0]);
          end
        end else if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_vec++; n_bad++;
          $display("FAIL missing_rvalid: got 0 expected 1 (a=%h b=%h)",
                   e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    idle_in();
    rst = 1;
    for (int i = 0; i < 16; i++) m[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // write then read back next cycle
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, "w5");
    step(0, 0, 0, 1, 5, 0, 0, 0, 0, "r5");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle2");

    // same-cycle write and read of both ports
    step(1, 3, 32'h12345678, 1, 3, 3, 0, 0, 0, "byp3");

    // writes to index 0 are discarded
    step(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, "w0");
    step(0, 0, 0, 1, 0, 5, 0, 0, 0, "r0");

    // busy register stalls until its writer lands
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, "iss7");
    step(0, 0, 0, 1, 0, 7, 0, 0, 1, "st7a");
    step(0, 0, 0, 1, 0, 7, 0, 0, 1, "st7b");
    step(1, 7, 32'h000000A5, 1, 0, 7, 0, 0, 0, "wb7");
    step(0, 0, 0, 1, 7, 3, 0, 0, 0, "r7");

    // issue and write to the same index: set wins
    step(1, 9, 32'h99, 0, 0, 0, 1, 9, 0, "iw9");
    step(0, 0, 0, 1, 9, 0, 0, 0, 1, "st9");
    step(1, 9, 32'h55, 1, 9, 0, 0, 0, 0, "wb9");

    // issue to index 0 is ignored
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, "iss0");
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, "r00");

    // issue and write to different indices both apply
    step(1, 11, 32'h11, 0, 0, 0, 1, 10, 0, "iw10");
    step(0, 0, 0, 1, 10, 11, 0, 0, 1, "st10");
    step(0, 0, 0, 1, 11, 11, 0, 0, 0, "r11");
    step(1, 10, 32'hAA, 1, 10, 11, 0, 0, 0, "wb10");

    // fill, mark busy, then reset clears everything
    for (int i = 1; i < 16; i++)
      step(1, 4'(i), 32'(i) * 32'h01010101, 0, 0, 0, 0, 0, 0, "fill");
    step(0, 0, 0, 1, 15, 1, 1, 4, 0, "rfill");
    step(0, 0, 0, 1, 4, 2, 0, 0, 1, "st4");
    do_reset();
    step(0, 0, 0, 1, 4, 15, 0, 0, 0, "pr4");
    step(0, 0, 0, 1, 1, 9, 0, 0, 0, "pr1");
    step(0, 0, 0, 1, 5, 7, 0, 0, 0, "pr5");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle3");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle4");

    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 4, register index width; NUM_REGS = 2**ADDR_W (16).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 we  input  1  write enable for the writeback port.
REQ-006 waddr  input  ADDR_W  writeback register index.
REQ-007 wdata  input  DATA_W  writeback data.
REQ-008 re  input  1  read request; samples raddr_a and raddr_b this cycle.
REQ-009 raddr_a, raddr_b  input  ADDR_W  read indices.
REQ-010 rdata_a, rdata_b  output  DATA_W  registered read data.
REQ-011 rvalid  output  1  pulses high one cycle after an accepted read.
REQ-012 issue  input  1  marks issue_addr busy (pending multi-cycle writer).
REQ-013 issue_addr  input  ADDR_W  destination index being issued.
REQ-014 stall  output  1  combinational; high when re is asserted and either read index is busy.

Function
REQ-015 Storage of NUM_REGS x DATA_W registers; register 0 reads as 0 always, and writes to index 0 are discarded.
REQ-016 Write: when we=1, reg[waddr] <= wdata at the rising edge.
REQ-017 Read acceptance: a read is accepted when re=1 and stall=0; an accepted read updates rdata_a/rdata_b at the next edge, and rvalid=1 for exactly that following cycle.
REQ-018 Read latency is exactly one cycle; while no read is accepted, rdata_a/rdata_b hold their last values and rvalid=0.
REQ-019 Write-first bypass: if an accepted read and a write to the same nonzero index occur in the same cycle, rdata returns that cycle's wdata.
REQ-020 Scoreboard: one busy bit per register; issue=1 sets busy[issue_addr]; we=1 clears busy[waddr].
REQ-021 Simultaneous issue and we to the same index: set wins (new writer pending); different indices: both take effect.
REQ-022 busy[0] is constant 0; an issue to index 0 is ignored.
REQ-023 stall evaluation: a busy bit cleared by a write in the current cycle does not stall (the bypass supplies the data).
REQ-024 A stalled read has no effect on state; the requester holds re and the addresses until stall drops.
REQ-025 Both read ports may name the same index; both return identical data.

Reset
REQ-026 When rst=1 at a rising edge: all registers <= 0, all busy bits <= 0, rdata_a/rdata_b <= 0, rvalid <= 0.
REQ-027 rst takes priority over we, re and issue in the same cycle; a read accepted in the reset cycle is dropped (no rvalid after reset).
REQ-028 Outputs are 0 and stall is 0 from the first cycle after reset release.

Structure
REQ-029 DATA_W, ADDR_W and NUM_REGS defaults live in the shared RISC constants header; no local redefinition.
REQ-030 The scoreboard (busy bits, set/clear priority, stall logic) is a separate sub-module named reg_scoreboard; storage, bypass and read registers stay in reg_file.

Verification
REQ-031 Reset, then we=1 waddr=5 wdata=0xDEADBEEF; next cycle re=1 raddr_a=5 -> one cycle later rdata_a=0xDEADBEEF, rvalid=1 for one cycle.
REQ-032 Same-cycle we=1 waddr=3 wdata=0x12345678 and re=1 raddr_a=3 raddr_b=3 -> next cycle rdata_a=rdata_b=0x12345678.
REQ-033 we=1 waddr=0 wdata=0xFFFFFFFF, then read index 0 -> rdata_a=0.
REQ-034 issue=1 issue_addr=7; next cycle re=1 raddr_b=7 -> stall=1, rvalid stays 0; then we=1 waddr=7 wdata=0xA5 -> stall=0 that cycle, next cycle rdata_b=0xA5.
REQ-035 Same cycle issue=1 issue_addr=9 and we=1 waddr=9 -> busy[9] remains set; a following read of 9 stalls.
REQ-036 Load registers 1..15 with nonzero values, set busy on 4, then rst=1 for one cycle -> all reads return 0, stall=0, rvalid=0.
